bootram_ctrl: RTL
=================

BOOTRAM_CTRL -- requirements
Module: bootram_ctrl

Interface
REQ-001 SHALL expose: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL expose: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL expose: mem_valid  in  1  CPU request valid (address decode done externally).
REQ-004 SHALL expose: mem_addr  in  32  byte address; only [12:2] used.
REQ-005 SHALL expose: mem_wdata  in  32  write data, lane n = [8n+7:8n].
REQ-006 SHALL expose: mem_wstrb  in  4  byte write strobes; 0000 = read.
REQ-007 SHALL expose: mem_ready  out  1  one-cycle completion pulse.
REQ-008 SHALL expose: mem_rdata  out  32  registered read data.
REQ-009 SHALL expose: ld_start  in  1  pulse; enter load mode.
REQ-010 SHALL expose: ld_valid  in  1, ld_data  in  8, ld_last  in  1  loader byte stream.
REQ-011 SHALL expose: ld_ready  out  1, ld_busy  out  1, ld_done  out  1  loader handshake, mode flag, completion pulse.
REQ-012 SHALL expose: ram_ce  out  4, ram_wre  out  4  per-lane RAM enables.
REQ-013 SHALL expose: ram_oce  out  1, ram_ad  out  11, ram_din  out  32, ram_dout  in  32  shared RAM port; lane n = [8n+7:8n].

Function
REQ-014 SHALL implement states IDLE, RD_WAIT, RESP, LOAD.
REQ-015 SHALL drive ram_oce constant 1.
REQ-016 In IDLE, with mem_valid=1 and ld_start=0, SHALL accept the request in the same cycle.
- ram_ad = mem_addr[12:2].
- ram_din = mem_wdata.
- Read: ram_ce = 1111, ram_wre = 0000.
- Write: ram_ce = ram_wre = mem_wstrb.
REQ-017 Read SHALL go IDLE->RD_WAIT->RESP->IDLE.
- RD_WAIT: capture ram_dout into mem_rdata.
- mem_ready = 1 in RESP, i.e. 2 cycles after acceptance.
REQ-018 Write SHALL go IDLE->RESP->IDLE, with mem_ready = 1 in RESP, 1 cycle after acceptance.
REQ-019 SHALL keep ram_ce = ram_wre = 0000 in RD_WAIT, in RESP, and in IDLE without accepted request or load entry.
REQ-020 SHALL NOT accept a new CPU request in RESP; the earliest next acceptance is the cycle after RESP.
REQ-021 SHALL leave mem_rdata unchanged on writes.
REQ-022 In IDLE, ld_start=1 SHALL enter LOAD, clear the 13-bit byte counter, and take priority over a simultaneous mem_valid (no RAM access that cycle).
REQ-023 SHALL ignore ld_start outside IDLE.
REQ-024 In LOAD: ld_busy = 1, ld_ready = 1.
- On ld_valid, for counter k, SHALL write ld_data to lane k[1:0] at word k[12:2]: ram_ce = ram_wre = one-hot(k[1:0]), ld_data replicated on all ram_din lanes.
- Counter SHALL increment by 1 per write.
REQ-025 LOAD SHALL exit to IDLE when the accepted byte has ld_last = 1 or k = 8191.
- ld_done = 1 for that single cycle.
- Counter wraps to 0.
- ld_busy = 0 from the next cycle.
REQ-026 mem_valid during LOAD SHALL NOT be accepted; mem_ready stays 0 and the request is served from IDLE after exit.
REQ-027 ld_ready SHALL be 0 outside LOAD; ld_valid outside LOAD SHALL be ignored.
REQ-028 mem_ready and ld_done SHALL never be high in the same cycle.

Reset
REQ-029 On reset assertion, SHALL immediately (asynchronously) force:
- state = IDLE;
- byte counter = 0, mem_rdata = 0;
- mem_ready, ld_ready, ld_busy, ld_done = 0.
REQ-030 While reset is asserted, ram_ce and ram_wre SHALL be 0000 regardless of mem_valid or ld_start.
REQ-031 Reset mid-read or mid-write SHALL abort the transaction: no mem_ready pulse.
REQ-032 Reset mid-load SHALL abort the load without ld_done; bytes already written SHALL remain in RAM.

Verification
REQ-033 Write 0x11223344, addr 0x10, wstrb 1111 -> acceptance cycle: ram_ad = 4, ram_ce = ram_wre = 1111; mem_ready +1 cycle. Read addr 0x10 -> mem_ready +2 cycles, mem_rdata = 0x11223344.
REQ-034 Then write 0xAABBCCDD, wstrb 0010, addr 0x10 -> only ram_wre[1]; read-back = 0x1122CC44.
REQ-035 ld_start, then bytes 01,02,03,04,05 (ld_last on 05) -> word0 = 0x04030201, word1 lane0 = 0x05; ld_done on the 5th byte; ld_busy = 0 the next cycle.
REQ-036 ld_start and mem_valid (read addr 0) in the same IDLE cycle -> LOAD entered, no RAM read; read completes after ld_done with the newly loaded word0.
REQ-037 Reset pulse during RD_WAIT -> no mem_ready; mem_rdata = 0; the next read behaves normally.
REQ-038 Stream 8192 bytes with ld_last = 0 -> ld_done on byte 8191, counter = 0, state IDLE.

Source files
------------

// File: rtl/bootram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : bootram_ctrl_if
// Description : CPU memory bus and loader byte stream for bootram_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface bootram_ctrl_if;
    // CPU bus
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    // Loader stream
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        ld_busy;
    logic        ld_done;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output ld_start, ld_valid, ld_data, ld_last,
        input  mem_ready, mem_rdata, ld_ready, ld_busy, ld_done
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  ld_start, ld_valid, ld_data, ld_last,
        output mem_ready, mem_rdata, ld_ready, ld_busy, ld_done
    );
endinterface
`default_nettype wire

// File: rtl/bootram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bootram_ctrl
// Description : Boot RAM controller. Serves CPU word reads/writes on a
//               byte-lane RAM and accepts a byte-serial image load stream.
// Revision    : 1.0 - initial release
// ============================================================================
module bootram_ctrl (
    input  wire logic        clk,
    input  wire logic        reset,
    bootram_ctrl_if.slave    bus,
    output logic [3:0]       ram_ce,
    output logic [3:0]       ram_wre,
    output logic             ram_oce,
    output logic [10:0]      ram_ad,
    output logic [31:0]      ram_din,
    input  wire logic [31:0] ram_dout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_RESP    = 2'd2,
        S_LOAD    = 2'd3
    } state_t;

    localparam logic [12:0] c_cnt_max = 13'd8191;

    state_t      r_state;
    logic [12:0] r_cnt;
    logic [31:0] r_rdata;
    logic        r_mem_ready;
    logic        r_ld_busy;

    logic        w_accept;
    logic        w_ld_write;
    logic        w_ld_exit;
    logic        w_unused;

    // A CPU request is taken only in IDLE and only when no load is starting.
    assign w_accept   = (r_state == S_IDLE) && !bus.ld_start && bus.mem_valid;
    assign w_ld_write = (r_state == S_LOAD) && bus.ld_valid;
    assign w_ld_exit  = w_ld_write && (bus.ld_last || (r_cnt == c_cnt_max));

    // Only word-address bits reach the RAM.
    assign w_unused = &{1'b0, bus.mem_addr[31:13], bus.mem_addr[1:0]};

    // Sequencer: request/response flow, loader counter and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 13'd0;
            r_rdata     <= 32'd0;
            r_mem_ready <= 1'b0;
            r_ld_busy   <= 1'b0;
        end else begin
            r_mem_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.ld_start) begin
                        r_state   <= S_LOAD;
                        r_cnt     <= 13'd0;
                        r_ld_busy <= 1'b1;
                    end else if (bus.mem_valid) begin
                        if (bus.mem_wstrb == 4'b0000) begin
                            r_state <= S_RD_WAIT;
                        end else begin
                            r_state     <= S_RESP;
                            r_mem_ready <= 1'b1;
                        end
                    end
                end
                S_RD_WAIT: begin
                    r_rdata     <= ram_dout;
                    r_state     <= S_RESP;
                    r_mem_ready <= 1'b1;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                S_LOAD: begin
                    if (w_ld_exit) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= 13'd0;
                        r_ld_busy <= 1'b0;
                    end else if (w_ld_write) begin
                        r_cnt <= r_cnt + 13'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // RAM port drive: CPU access on acceptance, single-lane byte write in LOAD.
    always_comb begin
        ram_ce  = 4'b0000;
        ram_wre = 4'b0000;
        ram_ad  = bus.mem_addr[12:2];
        ram_din = bus.mem_wdata;
        if (r_state == S_LOAD) begin
            ram_ad  = r_cnt[12:2];
            ram_din = {4{bus.ld_data}};
        end
        if (!reset) begin
            if (w_accept) begin
                ram_ce  = (bus.mem_wstrb == 4'b0000) ? 4'b1111 : bus.mem_wstrb;
                ram_wre = bus.mem_wstrb;
            end else if (w_ld_write) begin
                ram_ce  = 4'b0001 << r_cnt[1:0];
                ram_wre = 4'b0001 << r_cnt[1:0];
            end
        end
    end

    assign ram_oce       = 1'b1;
    assign bus.mem_ready = r_mem_ready;
    assign bus.mem_rdata = r_rdata;
    assign bus.ld_busy   = r_ld_busy;
    assign bus.ld_ready  = r_ld_busy;
    assign bus.ld_done   = w_ld_exit;

endmodule
`default_nettype wire
